lsu_unit: RTL and testbench

Load/store functional unit occupying FU slot 2 of the out-of-order core. It sits directly downstream of the reservation station: it consumes the memory-class entry issued on RS port 2 and reports its availability back through the FU-ready table. It computes the effective address, runs one byte-enabled request/acknowledge transaction to data memory, then broadcasts the load result on the writeback bus and a completion to the ROB.

---
 rtl/lsu_unit.sv | 184 ++++++++++++++++++
 tb/tb_lsu_unit.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_unit.sv
// Load/store unit on FU slot 2: one byte-enabled memory transaction per op,
// followed by a single-cycle writeback/ROB completion.
//
// state | meaning
// IDLE  | no op in flight, ready to accept
// REQ   | memory request outstanding, waiting for mem_ack_i
// RESP  | completion cycle (cmp_valid_o, wb_valid_o for loads); can accept
module lsu_unit #(
  parameter int PREG_WIDTH = 6,
  parameter int ROB_WIDTH  = 6
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  issue_valid_i,
  input  logic                  issue_store_i,
  input  logic [2:0]            issue_funct3_i,
  input  logic [31:0]           issue_base_i,
  input  logic [31:0]           issue_src2_i,
  input  logic [31:0]           issue_imm_i,
  input  logic [PREG_WIDTH-1:0] issue_rd_i,
  input  logic [ROB_WIDTH-1:0]  issue_rob_i,
  output logic                  fu_ready_o,
  output logic                  mem_req_o,
  output logic                  mem_we_o,
  output logic [31:0]           mem_addr_o,
  output logic [3:0]            mem_be_o,
  output logic [31:0]           mem_wdata_o,
  input  logic                  mem_ack_i,
  input  logic [31:0]           mem_rdata_i,
  output logic                  wb_valid_o,
  output logic [PREG_WIDTH-1:0] wb_rd_o,
  output logic [31:0]           wb_data_o,
  output logic                  cmp_valid_o,
  output logic [ROB_WIDTH-1:0]  cmp_rob_o,
  output logic                  cmp_exc_o
);

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

  state_t                state_q;
  logic                  mem_req_q, mem_we_q;
  logic [31:0]           mem_addr_q, mem_wdata_q;
  logic [3:0]            mem_be_q;
  logic                  wb_valid_q, cmp_valid_q, cmp_exc_q;
  logic [PREG_WIDTH-1:0] wb_rd_q;
  logic [31:0]           wb_data_q;
  logic [ROB_WIDTH-1:0]  cmp_rob_q;
  logic                  op_store_q;
  logic [2:0]            op_funct3_q;
  logic [1:0]            op_ea_lo_q;
  logic [PREG_WIDTH-1:0] op_rd_q;
  logic [ROB_WIDTH-1:0]  op_rob_q;

  logic [31:0] ea_d, src_trunc_d, wdata_d, lane_d, load_d;
  logic [3:0]  size_mask_d, be_d;
  logic        legal_d, misalign_d, bad_d;

  assign fu_ready_o = (state_q == IDLE) || (state_q == RESP);

  always_comb begin
    ea_d        = issue_base_i + issue_imm_i;
    legal_d     = 1'b0;
    misalign_d  = 1'b0;
    size_mask_d = 4'b0000;
    src_trunc_d = 32'h0;
    if (issue_store_i)
      legal_d = issue_funct3_i inside {3'b000, 3'b001, 3'b010};
    else
      legal_d = issue_funct3_i inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    case (issue_funct3_i[1:0])
      2'b00: begin
        size_mask_d = 4'b0001;
        src_trunc_d = {24'h0, issue_src2_i[7:0]};
      end
      2'b01: begin
        size_mask_d = 4'b0011;
        src_trunc_d = {16'h0, issue_src2_i[15:0]};
        misalign_d  = ea_d[0];
      end
      2'b10: begin
        size_mask_d = 4'b1111;
        src_trunc_d = issue_src2_i;
        misalign_d  = |ea_d[1:0];
      end
      default: begin
        size_mask_d = 4'b0000;
        src_trunc_d = 32'h0;
      end
    endcase
    be_d    = size_mask_d << ea_d[1:0];
    wdata_d = src_trunc_d << {ea_d[1:0], 3'b000};
    bad_d   = !legal_d || misalign_d;

    // Load lane extraction uses the offset captured at issue, not the live bus.
    lane_d = mem_rdata_i >> {op_ea_lo_q, 3'b000};
    case (op_funct3_q)
      3'b000:  load_d = {{24{lane_d[7]}}, lane_d[7:0]};
      3'b001:  load_d = {{16{lane_d[15]}}, lane_d[15:0]};
      3'b100:  load_d = {24'h0, lane_d[7:0]};
      3'b101:  load_d = {16'h0, lane_d[15:0]};
      default: load_d = lane_d;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 32'h0;
      mem_be_q    <= 4'b0000;
      mem_wdata_q <= 32'h0;
      wb_valid_q  <= 1'b0;
      wb_rd_q     <= '0;
      wb_data_q   <= 32'h0;
      cmp_valid_q <= 1'b0;
      cmp_rob_q   <= '0;
      cmp_exc_q   <= 1'b0;
      op_store_q  <= 1'b0;
      op_funct3_q <= 3'b000;
      op_ea_lo_q  <= 2'b00;
      op_rd_q     <= '0;
      op_rob_q    <= '0;
    end else begin
      cmp_valid_q <= 1'b0;
      wb_valid_q  <= 1'b0;
      case (state_q)
        IDLE, RESP: begin
          if (issue_valid_i) begin
            if (bad_d) begin
              // Faulting ops skip memory and complete on the next cycle.
              state_q     <= RESP;
              cmp_valid_q <= 1'b1;
              cmp_exc_q   <= 1'b1;
              cmp_rob_q   <= issue_rob_i;
            end else begin
              state_q     <= REQ;
              mem_req_q   <= 1'b1;
              mem_we_q    <= issue_store_i;
              mem_addr_q  <= {ea_d[31:2], 2'b00};
              mem_be_q    <= be_d;
              mem_wdata_q <= wdata_d;
              op_store_q  <= issue_store_i;
              op_funct3_q <= issue_funct3_i;
              op_ea_lo_q  <= ea_d[1:0];
              op_rd_q     <= issue_rd_i;
              op_rob_q    <= issue_rob_i;
            end
          end else begin
            state_q <= IDLE;
          end
        end
        REQ: begin
          if (mem_ack_i) begin
            state_q     <= RESP;
            mem_req_q   <= 1'b0;
            cmp_valid_q <= 1'b1;
            cmp_exc_q   <= 1'b0;
            cmp_rob_q   <= op_rob_q;
            if (!op_store_q) begin
              wb_valid_q <= 1'b1;
              wb_rd_q    <= op_rd_q;
              wb_data_q  <= load_d;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mem_req_o   = mem_req_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_be_o    = mem_be_q;
  assign mem_wdata_o = mem_wdata_q;
  assign wb_valid_o  = wb_valid_q;
  assign wb_rd_o     = wb_rd_q;
  assign wb_data_o   = wb_data_q;
  assign cmp_valid_o = cmp_valid_q;
  assign cmp_rob_o   = cmp_rob_q;
  assign cmp_exc_o   = cmp_exc_q;

endmodule

// File: tb/tb_lsu_unit.sv
// Directed bench for lsu_unit: vector table for single ops, plus hand-written
// back-to-back, protocol-violation and mid-request reset sequences.
module tb_lsu_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        issue_valid, issue_store;
  logic [2:0]  issue_funct3;
  logic [31:0] issue_base, issue_src2, issue_imm;
  logic [5:0]  issue_rd, issue_rob;
  logic        fu_ready, mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        wb_valid;
  logic [5:0]  wb_rd;
  logic [31:0] wb_data;
  logic        cmp_valid;
  logic [5:0]  cmp_rob;
  logic        cmp_exc;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  lsu_unit #(.PREG_WIDTH(6), .ROB_WIDTH(6)) dut (
    .clk_i(clk), .rst_i(rst),
    .issue_valid_i(issue_valid), .issue_store_i(issue_store),
    .issue_funct3_i(issue_funct3), .issue_base_i(issue_base),
    .issue_src2_i(issue_src2), .issue_imm_i(issue_imm),
    .issue_rd_i(issue_rd), .issue_rob_i(issue_rob),
    .fu_ready_o(fu_ready), .mem_req_o(mem_req), .mem_we_o(mem_we),
    .mem_addr_o(mem_addr), .mem_be_o(mem_be), .mem_wdata_o(mem_wdata),
    .mem_ack_i(mem_ack), .mem_rdata_i(mem_rdata),
    .wb_valid_o(wb_valid), .wb_rd_o(wb_rd), .wb_data_o(wb_data),
    .cmp_valid_o(cmp_valid), .cmp_rob_o(cmp_rob), .cmp_exc_o(cmp_exc)
  );

  typedef struct {
    logic        st;
    logic [2:0]  f3;
    logic [31:0] base;
    logic [31:0] imm;
    logic [31:0] src2;
    logic [31:0] rdata;
    int          k;
    logic        exc;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] wb;
  } vec_t;

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic st, input logic [2:0] f3,
                              input logic [31:0] base, input logic [31:0] imm,
                              input logic [31:0] src2, input logic [31:0] rdata,
                              input int k, input logic exc, input logic [31:0] addr,
                              input logic [3:0] be, input logic [31:0] wdata,
                              input logic [31:0] wb);
    vec_t v;
    v.st = st; v.f3 = f3; v.base = base; v.imm = imm; v.src2 = src2;
    v.rdata = rdata; v.k = k; v.exc = exc; v.addr = addr; v.be = be;
    v.wdata = wdata; v.wb = wb;
    return v;
  endfunction

  task automatic drive_issue(input logic st, input logic [2:0] f3, input logic [31:0] base,
                             input logic [31:0] imm, input logic [31:0] src2,
                             input logic [5:0] rd, input logic [5:0] rob);
    issue_valid = 1'b1; issue_store = st; issue_funct3 = f3;
    issue_base = base; issue_imm = imm; issue_src2 = src2;
    issue_rd = rd; issue_rob = rob;
  endtask

  // Called just after a posedge with the unit idle.
  task automatic run_vec(input vec_t v, input int idx);
    logic [5:0] rd, rob;
    rd  = 6'(idx + 1);
    rob = 6'(idx + 10);
    drive_issue(v.st, v.f3, v.base, v.imm, v.src2, rd, rob);
    chk1($sformatf("v%0d fu_ready before issue", idx), fu_ready, 1'b1);
    @(posedge clk); #1;
    issue_valid = 1'b0;
    if (v.exc) begin
      chk1($sformatf("v%0d exc mem_req", idx), mem_req, 1'b0);
      chk1($sformatf("v%0d exc cmp_valid", idx), cmp_valid, 1'b1);
      chk1($sformatf("v%0d exc cmp_exc", idx), cmp_exc, 1'b1);
      chk1($sformatf("v%0d exc wb_valid", idx), wb_valid, 1'b0);
      chk1($sformatf("v%0d exc fu_ready", idx), fu_ready, 1'b1);
      chk32($sformatf("v%0d exc cmp_rob", idx), {26'h0, cmp_rob}, {26'h0, rob});
    end else begin
      chk1($sformatf("v%0d mem_req", idx), mem_req, 1'b1);
      chk32($sformatf("v%0d mem_addr", idx), mem_addr, v.addr);
      chk32($sformatf("v%0d mem_be", idx), {28'h0, mem_be}, {28'h0, v.be});
      chk1($sformatf("v%0d mem_we", idx), mem_we, v.st);
      chk1($sformatf("v%0d fu_ready in REQ", idx), fu_ready, 1'b0);
      if (v.st) chk32($sformatf("v%0d mem_wdata", idx), mem_wdata, v.wdata);
      for (int c = 1; c < v.k; c++) begin
        @(posedge clk); #1;
        chk1($sformatf("v%0d wait%0d mem_req", idx, c), mem_req, 1'b1);
        chk32($sformatf("v%0d wait%0d mem_addr", idx, c), mem_addr, v.addr);
        chk32($sformatf("v%0d wait%0d mem_be", idx, c), {28'h0, mem_be}, {28'h0, v.be});
        chk1($sformatf("v%0d wait%0d fu_ready", idx, c), fu_ready, 1'b0);
        chk1($sformatf("v%0d wait%0d cmp_valid", idx, c), cmp_valid, 1'b0);
      end
      mem_ack = 1'b1; mem_rdata = v.rdata;
      @(posedge clk); #1;
      mem_ack = 1'b0; mem_rdata = 32'h0;
      chk1($sformatf("v%0d resp mem_req", idx), mem_req, 1'b0);
      chk1($sformatf("v%0d resp cmp_valid", idx), cmp_valid, 1'b1);
      chk1($sformatf("v%0d resp cmp_exc", idx), cmp_exc, 1'b0);
      chk32($sformatf("v%0d resp cmp_rob", idx), {26'h0, cmp_rob}, {26'h0, rob});
      chk1($sformatf("v%0d resp wb_valid", idx), wb_valid, !v.st);
      chk1($sformatf("v%0d resp fu_ready", idx), fu_ready, 1'b1);
      if (!v.st) begin
        chk32($sformatf("v%0d wb_rd", idx), {26'h0, wb_rd}, {26'h0, rd});
        chk32($sformatf("v%0d wb_data", idx), wb_data, v.wb);
      end
    end
    @(posedge clk); #1;
    chk1($sformatf("v%0d after cmp_valid", idx), cmp_valid, 1'b0);
    chk1($sformatf("v%0d after wb_valid", idx), wb_valid, 1'b0);
  endtask

  vec_t vecs[14];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; mem_ack = 1'b0; mem_rdata = 32'h0;
    issue_valid = 1'b0; issue_store = 1'b0; issue_funct3 = 3'b000;
    issue_base = 32'h0; issue_src2 = 32'h0; issue_imm = 32'h0;
    issue_rd = 6'h0; issue_rob = 6'h0;

    //               st  f3      base          imm           src2          rdata         k  exc  addr          be       wdata         wb
    vecs[0]  = mk(0, 3'b010, 32'h100,      32'h4,        32'h0,        32'hDEADBEEF, 1, 0, 32'h104,      4'b1111, 32'h0,        32'hDEADBEEF);
    vecs[1]  = mk(0, 3'b000, 32'h100,      32'h3,        32'h0,        32'h80123456, 1, 0, 32'h100,      4'b1000, 32'h0,        32'hFFFFFF80);
    vecs[2]  = mk(0, 3'b100, 32'h100,      32'h3,        32'h0,        32'h80123456, 1, 0, 32'h100,      4'b1000, 32'h0,        32'h00000080);
    vecs[3]  = mk(1, 3'b001, 32'h200,      32'h2,        32'h1234ABCD, 32'h0,        1, 0, 32'h200,      4'b1100, 32'hABCD0000, 32'h0);
    vecs[4]  = mk(0, 3'b010, 32'h100,      32'h1,        32'h0,        32'h0,        1, 1, 32'h0,        4'b0000, 32'h0,        32'h0);
    vecs[5]  = mk(0, 3'b011, 32'h100,      32'h0,        32'h0,        32'h0,        1, 1, 32'h0,        4'b0000, 32'h0,        32'h0);
    vecs[6]  = mk(0, 3'b001, 32'h100,      32'h2,        32'h0,        32'h80017FFF, 3, 0, 32'h100,      4'b1100, 32'h0,        32'hFFFF8001);
    vecs[7]  = mk(0, 3'b101, 32'h0,        32'h0,        32'h0,        32'h12349ABC, 2, 0, 32'h0,        4'b0011, 32'h0,        32'h00009ABC);
    vecs[8]  = mk(1, 3'b000, 32'h300,      32'h1,        32'hFFFFFF5A, 32'h0,        1, 0, 32'h300,      4'b0010, 32'h00005A00, 32'h0);
    vecs[9]  = mk(1, 3'b010, 32'h3FC,      32'h4,        32'hCAFEF00D, 32'h0,        2, 0, 32'h400,      4'b1111, 32'hCAFEF00D, 32'h0);
    vecs[10] = mk(1, 3'b100, 32'h400,      32'h0,        32'h11111111, 32'h0,        1, 1, 32'h0,        4'b0000, 32'h0,        32'h0);
    vecs[11] = mk(1, 3'b010, 32'h0,        32'h2,        32'h22222222, 32'h0,        1, 1, 32'h0,        4'b0000, 32'h0,        32'h0);
    vecs[12] = mk(0, 3'b010, 32'h1000,     32'hFFFFFFFC, 32'h0,        32'h11223344, 1, 0, 32'h00000FFC, 4'b1111, 32'h0,        32'h11223344);
    vecs[13] = mk(0, 3'b101, 32'h0,        32'h1,        32'h0,        32'h0,        1, 1, 32'h0,        4'b0000, 32'h0,        32'h0);

    #12;
    chk1("reset fu_ready", fu_ready, 1'b1);
    chk1("reset mem_req", mem_req, 1'b0);
    chk32("reset mem_addr", mem_addr, 32'h0);
    chk1("reset cmp_valid", cmp_valid, 1'b0);
    chk1("reset wb_valid", wb_valid, 1'b0);
    chk32("reset wb_data", wb_data, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 14; i++) run_vec(vecs[i], i);

    // Back-to-back ops with a protocol-violating issue while in REQ.
    drive_issue(1'b0, 3'b010, 32'h500, 32'h0, 32'h0, 6'd33, 6'd40);
    @(posedge clk); #1;
    drive_issue(1'b1, 3'b010, 32'h900, 32'h0, 32'h55555555, 6'd34, 6'd41);
    @(posedge clk); #1;
    issue_valid = 1'b0;
    chk32("b2b ignored issue mem_addr", mem_addr, 32'h500);
    chk1("b2b ignored issue mem_we", mem_we, 1'b0);
    chk1("b2b ignored issue mem_req", mem_req, 1'b1);
    mem_ack = 1'b1; mem_rdata = 32'hA5A5A5A5;
    @(posedge clk); #1;
    mem_ack = 1'b0;
    chk1("b2b op1 cmp_valid", cmp_valid, 1'b1);
    chk32("b2b op1 wb_data", wb_data, 32'hA5A5A5A5);
    chk32("b2b op1 cmp_rob", {26'h0, cmp_rob}, {26'h0, 6'd40});
    drive_issue(1'b1, 3'b000, 32'h600, 32'h2, 32'h000000C3, 6'd35, 6'd42);
    @(posedge clk); #1;
    issue_valid = 1'b0;
    chk1("b2b op2 mem_req", mem_req, 1'b1);
    chk32("b2b op2 mem_addr", mem_addr, 32'h600);
    chk32("b2b op2 mem_be", {28'h0, mem_be}, {28'h0, 4'b0100});
    chk32("b2b op2 mem_wdata", mem_wdata, 32'h00C30000);
    chk1("b2b op2 fu_ready", fu_ready, 1'b0);
    chk1("b2b op2 cmp_valid low", cmp_valid, 1'b0);
    chk32("b2b wb_data held", wb_data, 32'hA5A5A5A5);
    mem_ack = 1'b1;
    @(posedge clk); #1;
    mem_ack = 1'b0;
    chk1("b2b op2 cmp_valid", cmp_valid, 1'b1);
    chk1("b2b op2 wb_valid", wb_valid, 1'b0);
    chk32("b2b op2 cmp_rob", {26'h0, cmp_rob}, {26'h0, 6'd42});
    @(posedge clk); #1;

    // Asynchronous reset in the middle of a request.
    drive_issue(1'b0, 3'b010, 32'h700, 32'h0, 32'h0, 6'd36, 6'd43);
    @(posedge clk); #1;
    issue_valid = 1'b0;
    chk1("rst pre mem_req", mem_req, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    chk1("rst async mem_req", mem_req, 1'b0);
    chk1("rst async fu_ready", fu_ready, 1'b1);
    chk32("rst async mem_addr", mem_addr, 32'h0);
    chk32("rst async wb_data", wb_data, 32'h0);
    chk32("rst async cmp_rob", {26'h0, cmp_rob}, 32'h0);
    mem_ack = 1'b1; mem_rdata = 32'h77777777;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      chk1($sformatf("rst post%0d cmp_valid", c), cmp_valid, 1'b0);
      chk1($sformatf("rst post%0d wb_valid", c), wb_valid, 1'b0);
      chk1($sformatf("rst post%0d mem_req", c), mem_req, 1'b0);
      chk1($sformatf("rst post%0d fu_ready", c), fu_ready, 1'b1);
    end
    mem_ack = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
